carry_resolver: RTL
===================

CARRY_RESOLVER -- requirements
Module: carry_resolver

Interface
REQ-001 Parameter FF_CNT_W, default 8, width of the pending-0xFF run counter.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  byte offered by the final pipeline stage (qualified by pipeline_reg_final upstream).
REQ-005 in_byte  input  8  renormalized output byte.
REQ-006 in_carry  input  1  carry into previously produced bytes, accompanying in_byte.
REQ-007 in_flush  input  1  end of frame; drain all held bytes.
REQ-008 in_ready  output  1  block accepts in_valid/in_flush this cycle.
REQ-009 out_valid  output  1  out_byte is final.
REQ-010 out_byte  output  8  resolved bitstream byte.
REQ-011 out_ready  input  1  downstream accepts out_byte.
REQ-012 err_carry  output  1  sticky: carry received with no held byte.
REQ-013 err_ovf  output  1  sticky: 0xFF run exceeded 2^FF_CNT_W-1.
REQ-014 done  output  1  one-cycle pulse after flush drain completes.

Function
REQ-015 Internal state: held byte H, has_held flag, run counter R (FF_CNT_W bits), latched carry C.
REQ-016 States: EMPTY, HOLD, EMIT_HEAD, EMIT_RUN, DONE.
REQ-017 in_ready SHALL be 1 only in EMPTY and HOLD; input transfer = in_valid & in_ready.
REQ-018 EMPTY + transfer: H<=in_byte, R<=0, go HOLD; in_carry=1 sets err_carry and is otherwise dropped.
REQ-019 HOLD + transfer with in_carry=0 and in_byte=0xFF: R<=R+1, no output, stay HOLD.
REQ-020 HOLD + transfer with R at max and condition of REQ-019: set err_ovf, byte dropped, R unchanged.
REQ-021 HOLD + transfer otherwise: latch C<=in_carry, snapshot H and R for emission, load in_byte as new pending H, go EMIT_HEAD.
REQ-022 EMIT_HEAD: out_byte = H_snapshot + C (mod 256); on out_ready go EMIT_RUN if R_snapshot>0 else HOLD.
REQ-023 EMIT_RUN: out_byte = 0x00 if C else 0xFF; decrement R_snapshot per accepted byte; at last byte return to HOLD (or DONE if draining).
REQ-024 in_flush accepted in HOLD: emit H then R run with C=0, then DONE; in EMPTY: go DONE directly.
REQ-025 in_flush and in_valid in same cycle: byte processed first, flush applied after its emission, pending byte included in drain.
REQ-026 DONE: done=1 for exactly one cycle, then EMPTY with has_held=0, R=0.
REQ-027 out_valid registered; first output byte appears cycle N+1 after triggering transfer in cycle N.
REQ-028 out_valid/out_byte SHALL hold stable while out_valid=1 and out_ready=0.
REQ-029 Byte order out SHALL equal input order; no byte lost except per REQ-018/REQ-020.

Reset
REQ-030 reset asserted: state EMPTY, in_ready=1, out_valid=0, out_byte=0x00, R=0, C=0, err_carry=0, err_ovf=0, done=0, immediately and asynchronously.
REQ-031 Reset mid-emission discards all pending bytes; no partial run resumes after release.

Configuration
REQ-032 Macro CARRY_RESOLVER_STATS_EN defined: add output carry_count (16 bits, reset 0, increments on each accepted in_carry=1, saturates at 0xFFFF) and output max_run (FF_CNT_W bits, reset 0, largest R reached).
REQ-033 Macro undefined: those ports and their logic do not exist; all other behaviour identical.

Verification
REQ-034 Bytes 0x12,0x34 no carry, flush, out_ready=1 -> outputs 0x12,0x34, then done pulse.
REQ-035 0x7F, 0xFF, 0xFF, then 0x05 with carry -> outputs 0x80,0x00,0x00; flush -> 0x05.
REQ-036 0x7F, 0xFF, 0x10 no carry -> outputs 0x7F,0xFF; flush -> 0x10.
REQ-037 out_ready held 0 for 5 cycles during EMIT_RUN -> out_byte stable, in_ready=0, no bytes lost.
REQ-038 First byte with carry=1 -> err_carry=1 sticky; FF_CNT_W=2 with four consecutive 0xFF after held byte -> err_ovf=1.
REQ-039 reset asserted during EMIT_RUN -> out_valid=0 same cycle; after release new input 0x01, flush -> only 0x01.

Source files
------------

// File: rtl/carry_resolver.sv
// Resolves arithmetic-coder carries by holding the last byte plus a run of 0xFF until the carry is known.
// Latency: the first resolved byte is valid one cycle after the input transfer that triggers it.
// Backpressure: in_ready drops while a resolved group drains; outputs hold while out_ready=0. Optional stats: CARRY_RESOLVER_STATS_EN.
module carry_resolver #(
  parameter int FF_CNT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [7:0]          in_byte,
  input  logic                in_carry,
  input  logic                in_flush,
  output logic                in_ready,
  output logic                out_valid,
  output logic [7:0]          out_byte,
  input  logic                out_ready,
  output logic                err_carry,
  output logic                err_ovf,
  output logic                done
`ifdef CARRY_RESOLVER_STATS_EN
  ,
  output logic [15:0]         carry_count,
  output logic [FF_CNT_W-1:0] max_run
`endif
);

  typedef enum logic [2:0] {EMPTY, HOLD, EMIT_HEAD, EMIT_RUN, DONE} state_t;

  localparam logic [FF_CNT_W-1:0] RUN_MAX = '1;
  localparam logic [FF_CNT_W-1:0] RUN_ONE = FF_CNT_W'(1);

  state_t              state_q, state_d;
  logic [7:0]          hold_q, hold_d;
  logic                has_held_q, has_held_d;
  logic [FF_CNT_W-1:0] run_q, run_d;
  logic                carry_q, carry_d;
  logic [7:0]          head_q, head_d;
  logic [FF_CNT_W-1:0] left_q, left_d;
  logic                drain_q, drain_d;
  logic                flush_pend_q, flush_pend_d;
  logic                err_carry_d, err_ovf_d;
  logic                out_valid_d;
  logic [7:0]          out_byte_d;
  logic                xfer, ext_run, emit_end;
  logic [FF_CNT_W-1:0] run_inc;

  assign in_ready = (state_q == EMPTY) || (state_q == HOLD);
  assign done     = (state_q == DONE);
  assign xfer     = in_valid & in_ready;
  assign ext_run  = ~in_carry & (in_byte == 8'hFF);
  assign run_inc  = (run_q == RUN_MAX) ? run_q : run_q + RUN_ONE;

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    has_held_d   = has_held_q;
    run_d        = run_q;
    carry_d      = carry_q;
    head_d       = head_q;
    left_d       = left_q;
    drain_d      = drain_q;
    flush_pend_d = flush_pend_q;
    err_carry_d  = err_carry;
    err_ovf_d    = err_ovf;
    emit_end     = 1'b0;

    case (state_q)
      EMPTY: begin
        if (xfer) begin
          if (in_carry) err_carry_d = 1'b1;
          if (in_flush) begin
            head_d     = in_byte;
            left_d     = '0;
            carry_d    = 1'b0;
            drain_d    = 1'b1;
            has_held_d = 1'b0;
            run_d      = '0;
            state_d    = EMIT_HEAD;
          end else begin
            hold_d     = in_byte;
            run_d      = '0;
            has_held_d = 1'b1;
            state_d    = HOLD;
          end
        end else if (in_flush) begin
          state_d = DONE;
        end
      end
      HOLD: begin
        if (xfer && ext_run) begin
          if (run_q == RUN_MAX) err_ovf_d = 1'b1;
          run_d = run_inc;
          if (in_flush) begin
            head_d     = hold_q;
            left_d     = run_inc;
            carry_d    = 1'b0;
            drain_d    = 1'b1;
            has_held_d = 1'b0;
            run_d      = '0;
            state_d    = EMIT_HEAD;
          end
        end else if (xfer) begin
          // Carry resolves the held group; the new byte becomes the next held byte.
          carry_d      = in_carry;
          head_d       = hold_q;
          left_d       = run_q;
          hold_d       = in_byte;
          run_d        = '0;
          flush_pend_d = in_flush;
          state_d      = EMIT_HEAD;
        end else if (in_flush) begin
          head_d     = hold_q;
          left_d     = run_q;
          carry_d    = 1'b0;
          drain_d    = 1'b1;
          has_held_d = 1'b0;
          run_d      = '0;
          state_d    = EMIT_HEAD;
        end
      end
      EMIT_HEAD: begin
        if (out_ready) begin
          if (left_q != '0) state_d = EMIT_RUN;
          else              emit_end = 1'b1;
        end
      end
      EMIT_RUN: begin
        if (out_ready) begin
          left_d = left_q - RUN_ONE;
          if (left_q == RUN_ONE) emit_end = 1'b1;
        end
      end
      DONE: begin
        has_held_d   = 1'b0;
        run_d        = '0;
        drain_d      = 1'b0;
        flush_pend_d = 1'b0;
        carry_d      = 1'b0;
        state_d      = EMPTY;
      end
      default: state_d = EMPTY;
    endcase

    if (emit_end) begin
      if (drain_q) begin
        state_d = DONE;
      end else if (flush_pend_q) begin
        // Flush arrived with the resolving byte: drain that byte as well.
        head_d       = hold_q;
        left_d       = run_q;
        carry_d      = 1'b0;
        drain_d      = 1'b1;
        flush_pend_d = 1'b0;
        has_held_d   = 1'b0;
        run_d        = '0;
        state_d      = EMIT_HEAD;
      end else begin
        state_d = has_held_q ? HOLD : EMPTY;
      end
    end

    out_valid_d = (state_d == EMIT_HEAD) || (state_d == EMIT_RUN);
    out_byte_d  = 8'h00;
    if (state_d == EMIT_HEAD)     out_byte_d = head_d + {7'b0, carry_d};
    else if (state_d == EMIT_RUN) out_byte_d = carry_d ? 8'h00 : 8'hFF;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= EMPTY;
      hold_q       <= 8'h00;
      has_held_q   <= 1'b0;
      run_q        <= '0;
      carry_q      <= 1'b0;
      head_q       <= 8'h00;
      left_q       <= '0;
      drain_q      <= 1'b0;
      flush_pend_q <= 1'b0;
      err_carry    <= 1'b0;
      err_ovf      <= 1'b0;
      out_valid    <= 1'b0;
      out_byte     <= 8'h00;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      has_held_q   <= has_held_d;
      run_q        <= run_d;
      carry_q      <= carry_d;
      head_q       <= head_d;
      left_q       <= left_d;
      drain_q      <= drain_d;
      flush_pend_q <= flush_pend_d;
      err_carry    <= err_carry_d;
      err_ovf      <= err_ovf_d;
      out_valid    <= out_valid_d;
      out_byte     <= out_byte_d;
    end
  end

`ifdef CARRY_RESOLVER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry_count <= 16'h0000;
      max_run     <= '0;
    end else begin
      if (xfer && in_carry && (carry_count != 16'hFFFF)) carry_count <= carry_count + 16'h0001;
      if (run_d > max_run) max_run <= run_d;
    end
  end
`endif

endmodule
